// File: rtl/ones_pattern_tx_if.sv
// Start/ready request bus and serial/parallel result bus of ones_pattern_tx.
// A count source drives the master side; the transmitter is the slave.
interface ones_pattern_tx_if #(
  parameter int unsigned N  = 7,
  parameter int unsigned CW = 3
);
  logic          start;
  logic [CW-1:0] count;
  logic          ready;
  logic          sout;
  logic          sout_valid;
  logic          done;
  logic [N-1:0]  pattern;

  modport master (
    output start, count,
    input  ready, sout, sout_valid, done, pattern
  );

  modport slave (
    input  start, count,
    output ready, sout, sout_valid, done, pattern
  );
endinterface

// File: rtl/ones_pattern_tx.sv
// Serial thermometer-pattern transmitter: emits min(count, N) ones followed by
// zeros, LSB first, one bit per clock, and holds the parallel pattern.
module ones_pattern_tx #(
  parameter int unsigned N  = 7,
  parameter int unsigned CW = 3
) (
  input  logic             clk,
  input  logic             rst,
  ones_pattern_tx_if.slave bus
);

  localparam int unsigned   IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(N);
  localparam logic [IW-1:0] ILAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sh, sh_nxt;
  logic [N-1:0]  pattern_q, pattern_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [N-1:0]  therm_c;
  logic [CW-1:0] sat_c;
  logic          ready_q, sout_q, valid_q, done_q;
  logic          ready_nxt, sout_nxt, valid_nxt, done_nxt;

  // Saturated count expanded into a thermometer code.
  always_comb begin
    sat_c = (bus.count > CMAX) ? CMAX : bus.count;
    for (int i = 0; i < N; i++) begin
      therm_c[i] = (CW'(i) < sat_c);
    end
  end

  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    idx_nxt     = idx;
    pattern_nxt = pattern_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sh_nxt      = therm_c;
          pattern_nxt = therm_c;
          idx_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        sh_nxt  = sh >> 1;
        idx_nxt = idx + IW'(1);
        if (idx == ILAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_nxt = (state_nxt == IDLE);
    valid_nxt = (state_nxt == SHIFT);
    sout_nxt  = valid_nxt & sh_nxt[0];
    done_nxt  = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      idx       <= '0;
      pattern_q <= '0;
      ready_q   <= 1'b1;
      sout_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      idx       <= idx_nxt;
      pattern_q <= pattern_nxt;
      ready_q   <= ready_nxt;
      sout_q    <= sout_nxt;
      valid_q   <= valid_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.pattern    = pattern_q;

endmodule

// File: tb/tb_ones_pattern_tx.sv
// Directed bench for ones_pattern_tx: reset, frame timing, boundary counts,
// busy rejection, loopback through a 7-input ones counter, and saturation.
module tb_ones_pattern_tx;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ones_pattern_tx_if #(.N(7), .CW(3)) bus7 ();
  ones_pattern_tx_if #(.N(5), .CW(3)) bus5 ();

  ones_pattern_tx #(.N(7), .CW(3)) dut7 (.clk(clk), .rst(rst), .bus(bus7));
  ones_pattern_tx #(.N(5), .CW(3)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // 7-input ones counter used as the loopback reference.
  function automatic int unsigned ones7(input logic [6:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 7; i++) n += 32'(v[i]);
    return n;
  endfunction

  // One frame on the N=7 instance, starting from IDLE; ends in the ready cycle.
  task automatic frame7(input logic [2:0] cnt, input logic [6:0] exp_pat,
                        input logic hold_start, input logic [2:0] hold_cnt);
    bus7.start = 1'b1;
    bus7.count = cnt;
    tick();
    bus7.start = hold_start;
    bus7.count = hold_cnt;
    chk("pattern", 32'(bus7.pattern), 32'(exp_pat));
    chk("loopback", ones7(bus7.pattern), 32'(cnt));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("sout[%0d] cnt=%0d", i, cnt), 32'(bus7.sout), 32'(exp_pat[i]));
      chk("sout_valid", 32'(bus7.sout_valid), 32'd1);
      chk("ready_busy", 32'(bus7.ready), 32'd0);
      chk("done_early", 32'(bus7.done), 32'd0);
      tick();
    end
    chk("done_pulse", 32'(bus7.done), 32'd1);
    chk("valid_in_done", 32'(bus7.sout_valid), 32'd0);
    chk("ready_in_done", 32'(bus7.ready), 32'd0);
    tick();
    chk("ready_back", 32'(bus7.ready), 32'd1);
    chk("done_cleared", 32'(bus7.done), 32'd0);
    chk("pattern_hold", 32'(bus7.pattern), 32'(exp_pat));
  endtask

  logic [6:0] therm_tbl [8];
  int         done_seen;

  initial begin
    therm_tbl[0] = 7'b0000000; therm_tbl[1] = 7'b0000001;
    therm_tbl[2] = 7'b0000011; therm_tbl[3] = 7'b0000111;
    therm_tbl[4] = 7'b0001111; therm_tbl[5] = 7'b0011111;
    therm_tbl[6] = 7'b0111111; therm_tbl[7] = 7'b1111111;

    rst = 1'b1;
    bus7.start = 1'b0; bus7.count = '0;
    bus5.start = 1'b0; bus5.count = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus7.ready), 32'd1);
    chk("rst_valid", 32'(bus7.sout_valid), 32'd0);
    chk("rst_sout", 32'(bus7.sout), 32'd0);
    chk("rst_done", 32'(bus7.done), 32'd0);
    chk("rst_pattern", 32'(bus7.pattern), 32'd0);

    // count=3 with count changing after the accept edge
    frame7(3'd3, 7'b0000111, 1'b0, 3'd5);

    // boundary counts
    frame7(3'd0, 7'b0000000, 1'b0, 3'd0);
    frame7(3'd7, 7'b1111111, 1'b0, 3'd0);

    // busy rejection, then start held high in IDLE
    frame7(3'd2, 7'b0000011, 1'b1, 3'd6);
    frame7(3'd6, 7'b0111111, 1'b0, 3'd0);

    // loopback over every count
    for (int c = 0; c < 8; c++) begin
      frame7(3'(c), therm_tbl[c], 1'b0, 3'd0);
    end

    // reset mid-frame: count=5, two bits out, then rst for two cycles
    bus7.start = 1'b1; bus7.count = 3'd5;
    tick();
    bus7.start = 1'b0;
    chk("pre_rst_pattern", 32'(bus7.pattern), 32'h1f);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 32'(bus7.ready), 32'd1);
    chk("midrst_valid", 32'(bus7.sout_valid), 32'd0);
    tick();
    rst = 1'b0;
    chk("postrst_ready", 32'(bus7.ready), 32'd1);
    chk("postrst_valid", 32'(bus7.sout_valid), 32'd0);
    chk("postrst_done", 32'(bus7.done), 32'd0);
    chk("postrst_pattern", 32'(bus7.pattern), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus7.done || bus7.sout_valid) done_seen++;
      tick();
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);

    // saturation on the N=5 instance
    bus5.start = 1'b1; bus5.count = 3'd7;
    tick();
    bus5.start = 1'b0;
    chk("sat_pattern", 32'(bus5.pattern), 32'h1f);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sat_sout[%0d]", i), 32'(bus5.sout), 32'd1);
      chk("sat_valid", 32'(bus5.sout_valid), 32'd1);
      tick();
    end
    chk("sat_done", 32'(bus5.done), 32'd1);
    chk("sat_valid_off", 32'(bus5.sout_valid), 32'd0);
    tick();
    chk("sat_ready", 32'(bus5.ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
